// File: rtl/sense_hold_timer_if.sv
// Bundle of sensor inputs, enable gating and per-channel hold status for sense_hold_timer.
// The slave side is the timer itself; the master side drives sensors and enable.
interface sense_hold_timer_if #(
  parameter int CHANNELS = 4,
  parameter int CW       = 3
);
  logic                   enable;
  logic [CHANNELS-1:0]    sense;
  logic                   tick;
  logic [CHANNELS-1:0]    active;
  logic [CHANNELS-1:0]    done;
  logic [CHANNELS*CW-1:0] remaining;

  modport master (
    output enable, sense,
    input  tick, active, done, remaining
  );

  modport slave (
    input  enable, sense,
    output tick, active, done, remaining
  );
endinterface

// File: rtl/sense_hold_timer.sv
// Multi-channel retriggerable hold timer: synchronised sensor rise starts a per-channel
// hold of HOLD_TICKS prescaler ticks, then a one-cycle done pulse.
module sense_hold_timer #(
  parameter int CHANNELS   = 4,
  parameter int HOLD_TICKS = 5,
  parameter int TICK_DIV   = 50000000,
  parameter int RETRIGGER  = 0
) (
  input  logic             clk,
  input  logic             Reset,
  sense_hold_timer_if.slave bus
);
  localparam int CW = $clog2(HOLD_TICKS + 1);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_TICKS);

  typedef enum logic {IDLE, HOLD} stateT;

  logic [DW-1:0]       r_div;
  logic                r_tick;
  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_s2;
  logic [CHANNELS-1:0] r_prev;
  logic [CHANNELS-1:0] w_rise;
  stateT               r_state     [CHANNELS];
  stateT               w_stateNext [CHANNELS];
  logic [CW-1:0]       r_rem       [CHANNELS];
  logic [CW-1:0]       w_remNext   [CHANNELS];
  logic [CHANNELS-1:0] r_active;
  logic [CHANNELS-1:0] r_done;
  logic [CHANNELS-1:0] w_doneNext;
  logic [CHANNELS*CW-1:0] w_remFlat;

  // Free-running prescaler; held at phase 0 while disabled so ticks stop immediately.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (!bus.enable) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_div == DIV_LAST);
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= bus.sense;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_prev;

  // A retrigger reload takes priority over a same-cycle tick, including the final one.
  always_comb begin
    w_doneNext = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_stateNext[i] = r_state[i];
      w_remNext[i]   = r_rem[i];
      case (r_state[i])
        IDLE: begin
          if (w_rise[i] && bus.enable) begin
            w_stateNext[i] = HOLD;
            w_remNext[i]   = HOLD_LOAD;
          end
        end
        HOLD: begin
          if ((RETRIGGER != 0) && w_rise[i] && bus.enable) begin
            w_remNext[i] = HOLD_LOAD;
          end else if (r_tick) begin
            if (r_rem[i] == CW'(1)) begin
              w_stateNext[i] = IDLE;
              w_remNext[i]   = '0;
              w_doneNext[i]  = 1'b1;
            end else begin
              w_remNext[i] = r_rem[i] - 1'b1;
            end
          end
        end
        default: begin
          w_stateNext[i] = IDLE;
          w_remNext[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_active <= '0;
      r_done   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i] <= IDLE;
        r_rem[i]   <= '0;
      end
    end else begin
      r_done <= w_doneNext;
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= w_stateNext[i];
        r_rem[i]    <= w_remNext[i];
        r_active[i] <= (w_stateNext[i] == HOLD);
      end
    end
  end

  always_comb begin
    w_remFlat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_remFlat[i*CW +: CW] = r_rem[i];
    end
  end

  assign bus.tick      = r_tick;
  assign bus.active    = r_active;
  assign bus.done      = r_done;
  assign bus.remaining = w_remFlat;
endmodule

// File: tb/tb_sense_hold_timer.sv
// Bench for sense_hold_timer: three instances (plain, retrigger, retrigger with TICK_DIV=1)
// share stimulus; a behavioural model feeds a scoreboard, plus hand-derived spot checks.
module tb_sense_hold_timer;
  localparam int HOLD = 3;
  localparam int NI   = 3;
  localparam int P_DIV [NI]    = '{4, 4, 1};
  localparam int P_RETRIG [NI] = '{0, 1, 1};

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  sense_hold_timer_if #(.CHANNELS(4), .CW(2)) ifA ();
  sense_hold_timer_if #(.CHANNELS(4), .CW(2)) ifB ();
  sense_hold_timer_if #(.CHANNELS(4), .CW(2)) ifC ();

  sense_hold_timer #(.CHANNELS(4), .HOLD_TICKS(HOLD), .TICK_DIV(4), .RETRIGGER(0))
    dutA (.clk(clk), .Reset(Reset), .bus(ifA));
  sense_hold_timer #(.CHANNELS(4), .HOLD_TICKS(HOLD), .TICK_DIV(4), .RETRIGGER(1))
    dutB (.clk(clk), .Reset(Reset), .bus(ifB));
  sense_hold_timer #(.CHANNELS(4), .HOLD_TICKS(HOLD), .TICK_DIV(1), .RETRIGGER(1))
    dutC (.clk(clk), .Reset(Reset), .bus(ifC));

  typedef struct {
    logic       tick;
    logic [3:0] act;
    logic [3:0] done;
    logic [7:0] rem;
  } expT;

  typedef struct {
    bit       rst;
    bit       en;
    bit [3:0] sense;
    int       reps;
    bit       chk;
    bit [3:0] expAct;
    bit [3:0] expDone;
    int       expRem0;
  } vecT;

  expT sbQ[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cycleNo = 0;

  int       mCnt  [NI];
  bit       mTick [NI];
  bit [3:0] mS1   [NI];
  bit [3:0] mS2   [NI];
  bit [3:0] mPrev [NI];
  bit [3:0] mDone [NI];
  int       mRem  [NI][4];

  // Remaining count doubles as the state: zero means idle.
  task automatic modelStep(input int k, input bit rst, input bit en, input bit [3:0] s);
    bit [3:0] rise;
    bit       tickNow;
    if (rst) begin
      mCnt[k] = 0; mTick[k] = 0; mS1[k] = 0; mS2[k] = 0; mPrev[k] = 0; mDone[k] = 0;
      for (int c = 0; c < 4; c++) mRem[k][c] = 0;
    end else begin
      rise    = mS2[k] & ~mPrev[k];
      tickNow = mTick[k];
      for (int c = 0; c < 4; c++) begin
        mDone[k][c] = 1'b0;
        if (mRem[k][c] == 0) begin
          if (rise[c] && en) mRem[k][c] = HOLD;
        end else if (rise[c] && en && (P_RETRIG[k] != 0)) begin
          mRem[k][c] = HOLD;
        end else if (tickNow) begin
          mRem[k][c] = mRem[k][c] - 1;
          if (mRem[k][c] == 0) mDone[k][c] = 1'b1;
        end
      end
      if (!en) begin
        mCnt[k]  = 0;
        mTick[k] = 0;
      end else begin
        mTick[k] = (mCnt[k] == P_DIV[k] - 1);
        mCnt[k]  = (mCnt[k] + 1) % P_DIV[k];
      end
      mPrev[k] = mS2[k];
      mS2[k]   = mS1[k];
      mS1[k]   = s;
    end
  endtask

  function automatic expT getActual(input int k);
    expT a;
    case (k)
      0:       begin a.tick = ifA.tick; a.act = ifA.active; a.done = ifA.done; a.rem = ifA.remaining; end
      1:       begin a.tick = ifB.tick; a.act = ifB.active; a.done = ifB.done; a.rem = ifB.remaining; end
      default: begin a.tick = ifC.tick; a.act = ifC.active; a.done = ifC.done; a.rem = ifC.remaining; end
    endcase
    return a;
  endfunction

  task automatic checkOutput();
    expT e;
    expT a;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      a = getActual(k);
      if (sbQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL dut%0d_cyc%0d: scoreboard empty", k, cycleNo);
      end else begin
        e = sbQ.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("[TB] FAIL dut%0d_cyc%0d: got tick=%0b act=%b done=%b rem=%h, expected tick=%0b act=%b done=%b rem=%h",
                   k, cycleNo, a.tick, a.act, a.done, a.rem, e.tick, e.act, e.done, e.rem);
        end
      end
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock per repetition: drive, predict, push, then compare just after the edge.
  task automatic applyStimulus(input bit rst, input bit en, input bit [3:0] s, input int reps);
    expT e;
    for (int r = 0; r < reps; r++) begin
      Reset = rst;
      ifA.enable = en; ifB.enable = en; ifC.enable = en;
      ifA.sense = s;   ifB.sense = s;   ifC.sense = s;
      for (int k = 0; k < NI; k++) begin
        modelStep(k, rst, en, s);
        e.tick = mTick[k];
        e.done = mDone[k];
        for (int c = 0; c < 4; c++) begin
          e.act[c]       = (mRem[k][c] != 0);
          e.rem[c*2 +: 2] = 2'(mRem[k][c]);
        end
        sbQ.push_back(e);
      end
      @(posedge clk);
      #1;
      cycleNo++;
      checkOutput();
    end
  endtask

  vecT vecs [10];

  initial begin
    for (int k = 0; k < NI; k++) modelStep(k, 1'b1, 1'b0, 4'b0);

    vecs[0] = '{1'b1, 1'b1, 4'b0000, 3, 1'b1, 4'b0000, 4'b0000, 0};
    vecs[1] = '{1'b0, 1'b1, 4'b0000, 5, 1'b0, 4'b0000, 4'b0000, 0};
    vecs[2] = '{1'b0, 1'b1, 4'b0001, 2, 1'b1, 4'b0000, 4'b0000, 0};
    vecs[3] = '{1'b0, 1'b1, 4'b0001, 1, 1'b1, 4'b0001, 4'b0000, 3};
    vecs[4] = '{1'b0, 1'b1, 4'b0001, 1, 1'b1, 4'b0001, 4'b0000, 2};
    vecs[5] = '{1'b0, 1'b1, 4'b0000, 3, 1'b1, 4'b0001, 4'b0000, 2};
    vecs[6] = '{1'b0, 1'b1, 4'b0000, 1, 1'b1, 4'b0001, 4'b0000, 1};
    vecs[7] = '{1'b0, 1'b1, 4'b0000, 3, 1'b1, 4'b0001, 4'b0000, 1};
    vecs[8] = '{1'b0, 1'b1, 4'b0000, 1, 1'b1, 4'b0000, 4'b0001, 0};
    vecs[9] = '{1'b0, 1'b1, 4'b0000, 1, 1'b1, 4'b0000, 4'b0000, 0};

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].sense, vecs[v].reps);
      if (vecs[v].chk) begin
        checkValue($sformatf("vec%0d_active", v), int'(ifA.active), int'(vecs[v].expAct));
        checkValue($sformatf("vec%0d_done", v), int'(ifA.done), int'(vecs[v].expDone));
        checkValue($sformatf("vec%0d_rem0", v), int'(ifA.remaining[1:0]), vecs[v].expRem0);
      end
    end

    $display("[TB] retrigger at remaining=1");
    applyStimulus(1, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b0000, 5);
    applyStimulus(0, 1, 4'b0001, 3);
    applyStimulus(0, 1, 4'b0000, 4);
    applyStimulus(0, 1, 4'b0001, 3);
    applyStimulus(0, 1, 4'b0000, 2);
    checkValue("retrig_A_done", int'(ifA.done[0]), 1);
    checkValue("retrig_B_active", int'(ifB.active[0]), 1);
    checkValue("retrig_B_rem0", int'(ifB.remaining[1:0]), 2);
    applyStimulus(0, 1, 4'b0000, 10);

    $display("[TB] independent channels");
    applyStimulus(1, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b1010, 5);
    applyStimulus(0, 1, 4'b1110, 2);
    applyStimulus(0, 1, 4'b0000, 25);

    $display("[TB] enable gating");
    applyStimulus(1, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b0000, 5);
    applyStimulus(0, 1, 4'b0001, 4);
    applyStimulus(0, 0, 4'b0001, 10);
    applyStimulus(0, 0, 4'b0101, 5);
    applyStimulus(0, 0, 4'b0001, 5);
    checkValue("gate_tick", int'(ifA.tick), 0);
    checkValue("gate_rem0", int'(ifA.remaining[1:0]), 2);
    checkValue("gate_active", int'(ifA.active), 1);
    applyStimulus(0, 1, 4'b0000, 5);
    checkValue("resume_rem0", int'(ifA.remaining[1:0]), 1);
    applyStimulus(0, 1, 4'b0000, 15);

    $display("[TB] reset mid-hold");
    applyStimulus(1, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b0000, 5);
    applyStimulus(0, 1, 4'b0001, 4);
    applyStimulus(1, 1, 4'b0001, 1);
    checkValue("rst_active", int'(ifA.active), 0);
    checkValue("rst_rem", int'(ifA.remaining), 0);
    checkValue("rst_done", int'(ifA.done), 0);
    applyStimulus(1, 1, 4'b0001, 2);
    applyStimulus(0, 1, 4'b0001, 2);
    checkValue("release_wait_active", int'(ifA.active[0]), 0);
    applyStimulus(0, 1, 4'b0001, 1);
    checkValue("release_active", int'(ifA.active[0]), 1);
    checkValue("release_rem0", int'(ifA.remaining[1:0]), 3);
    applyStimulus(0, 1, 4'b0001, 20);

    $display("[TB] rise on final tick");
    applyStimulus(1, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b0000, 3);
    applyStimulus(0, 1, 4'b0001, 1);
    applyStimulus(0, 1, 4'b0000, 2);
    applyStimulus(0, 1, 4'b0001, 1);
    applyStimulus(0, 1, 4'b0000, 2);
    checkValue("final_C_active", int'(ifC.active[0]), 1);
    checkValue("final_C_rem0", int'(ifC.remaining[1:0]), 3);
    checkValue("final_C_done", int'(ifC.done[0]), 0);
    applyStimulus(0, 1, 4'b0000, 10);

    $display("[TB] random traffic");
    for (int i = 0; i < 200; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
